// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I controller.
// Holds the state encodings, the opcodes the controller recognises, and the
// encodings of every datapath select it drives. No ports.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps alu_op plus the instruction function fields to the ALU
// operation code.
// Ports: alu_op (2), funct3 (3), funct7_5, op5 in; alu_control (3) out.
// alu_control: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
import multicycle_control_fsm_pkg::*;

module alu_decoder (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALUOP_ADD: alu_control = 3'b000;
      ALUOP_SUB: alu_control = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5=1) can request sub; addi with imm[30]=1 stays add.
          3'b000:  alu_control = (op5 && funct7_5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b100:  alu_control = 3'b100;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle RV32I datapath. Steps each instruction
// through fetch, decode, execute, memory and writeback and drives the
// datapath selects / enables. Outputs are decoded from the state register,
// with mem_ready gating the fetch enables and zero gating the branch.
// Ports: clk, reset (sync, active-high), op/funct3/funct7_5 from the IR,
// zero, mem_ready in; pc_write, adr_src, mem_write, ir_write, result_src,
// alu_src_a, alu_src_b, alu_op, alu_control, imm_src, reg_write,
// illegal_op out.
import multicycle_control_fsm_pkg::*;

module multicycle_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal_op
);

  state_t r_state;
  logic   w_mem_ready;

  assign w_mem_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    r_state <= w_mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECUTER;
            OP_I:         r_state <= S_EXECUTEI;
            OP_BEQ:       r_state <= S_BEQ;
            OP_JAL:       r_state <= S_JAL;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= w_mem_ready ? S_MEMWB : S_MEMREAD;
        S_MEMWRITE: r_state <= w_mem_ready ? S_FETCH : S_MEMWRITE;
        S_MEMWB:    r_state <= S_FETCH;
        S_EXECUTER: r_state <= S_ALUWB;
        S_EXECUTEI: r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BEQ:      r_state <= S_FETCH;
        // JAL computes PC+4 into ALUOut, then ALUWB writes it to rd.
        S_JAL:      r_state <= S_ALUWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    if (reset) begin
      // Present fetch selects but suppress every write while in reset.
      alu_src_b  = SRCB_FOUR;
      result_src = RES_ALURESULT;
    end else begin
      case (r_state)
        S_FETCH: begin
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          ir_write   = w_mem_ready;
          pc_write   = w_mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_op = 1'b0;
            default:                                  illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: adr_src = 1'b1;
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_EXECUTER: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_FUNCT;
        end
        S_EXECUTEI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_SUB;
          pc_write  = zero;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule
